// File: rtl/time_keeper_if.sv
// Signal bundle between the time keeper and its user: the 1 Hz input, the
// set-mode controls, and the registered BCD display outputs.
// None of these signals uses a valid/ready handshake. Inputs are levels or
// single-cycle pulses sampled on clk_100Mhz. Outputs are registered and
// change only on a clk_100Mhz edge.
interface time_keeper_if;
  logic       clk_1hz;
  logic       set_mode;
  logic       inc_min;
  logic       inc_hour;
  logic [3:0] sec_ones;
  logic [3:0] sec_tens;
  logic [3:0] min_ones;
  logic [3:0] min_tens;
  logic [3:0] hr_ones;
  logic [3:0] hr_tens;
  logic       pm;
  logic       sec_tick;

  modport master (
    output clk_1hz, set_mode, inc_min, inc_hour,
    input  sec_ones, sec_tens, min_ones, min_tens, hr_ones, hr_tens, pm, sec_tick
  );

  modport slave (
    input  clk_1hz, set_mode, inc_min, inc_hour,
    output sec_ones, sec_tens, min_ones, min_tens, hr_ones, hr_tens, pm, sec_tick
  );
endinterface

// File: rtl/time_keeper.sv
// BCD clock counter. It counts seconds from a synchronized 1 Hz input and
// lets the user set the time with minute and hour increment pulses.
// MODE_24H=1 gives a 00..23 hour count. MODE_24H=0 gives 12,01..11 with an
// AM/PM flag.
module time_keeper #(
  parameter int unsigned MODE_24H = 1
) (
  input logic         clk_100Mhz,
  input logic         reset,
  time_keeper_if.slave bus
);

  localparam bit         IS_24H   = (MODE_24H != 0);
  localparam logic [3:0] HR_RST_T = IS_24H ? 4'd0 : 4'd1;
  localparam logic [3:0] HR_RST_O = IS_24H ? 4'd0 : 4'd2;

  logic       s1, s2, s3;
  logic       tick;
  logic [3:0] so, st, mo, mt, ho, ht;
  logic       pm_q, sec_tick_q;
  logic [3:0] so_n, st_n, mo_n, mt_n, ho_n, ht_n;
  logic       pm_n, sec_tick_n;
  logic [8:0] sec_inc, min_inc, hr_inc;

  // Add one to a 00..59 BCD pair. Result is {carry_out, tens, ones}.
  function automatic logic [8:0] inc_sexa(input logic [3:0] t, input logic [3:0] o);
    logic [8:0] r;
    if (o != 4'd9)      r = {1'b0, t, o + 4'd1};
    else if (t != 4'd5) r = {1'b0, t + 4'd1, 4'd0};
    else                r = {1'b1, 8'h00};
    return r;
  endfunction

  // Add one to the hour for the chosen mode. Result is {pm, tens, ones}.
  // In 12-hour mode, pm flips when the hour goes from 11 to 12.
  function automatic logic [8:0] inc_hr(input logic [3:0] t, input logic [3:0] o, input logic p);
    logic [8:0] r;
    if (IS_24H) begin
      if (t == 4'd2 && o == 4'd3) r = {1'b0, 4'd0, 4'd0};
      else if (o == 4'd9)         r = {1'b0, t + 4'd1, 4'd0};
      else                        r = {1'b0, t, o + 4'd1};
    end else begin
      if (t == 4'd1 && o == 4'd2)      r = {p, 4'd0, 4'd1};
      else if (t == 4'd1 && o == 4'd1) r = {~p, 4'd1, 4'd2};
      else if (o == 4'd9)              r = {p, 4'd1, 4'd0};
      else                             r = {p, t, o + 4'd1};
    end
    return r;
  endfunction

  // A tick is one cycle of high on s2 while s3 is still low, so each rising
  // edge of clk_1hz produces a single tick no matter how long it stays high.
  assign tick    = s2 & ~s3;
  assign sec_inc = inc_sexa(st, so);
  assign min_inc = inc_sexa(mt, mo);
  assign hr_inc  = inc_hr(ht, ho, pm_q);

  // Compute the next time. Set mode takes priority over a tick, and all
  // carries settle within one edge, so no illegal digit is ever registered.
  always_comb begin
    so_n       = so;
    st_n       = st;
    mo_n       = mo;
    mt_n       = mt;
    ho_n       = ho;
    ht_n       = ht;
    pm_n       = pm_q;
    sec_tick_n = 1'b0;
    if (bus.set_mode) begin
      so_n = 4'd0;
      st_n = 4'd0;
      if (bus.inc_min)  {mt_n, mo_n} = min_inc[7:0];
      if (bus.inc_hour) {pm_n, ht_n, ho_n} = hr_inc;
    end else if (tick) begin
      sec_tick_n   = 1'b1;
      {st_n, so_n} = sec_inc[7:0];
      if (sec_inc[8]) begin
        {mt_n, mo_n} = min_inc[7:0];
        if (min_inc[8]) {pm_n, ht_n, ho_n} = hr_inc;
      end
    end
  end

  // Synchronizer, edge history and time registers. The synchronizer keeps
  // running in set mode, so leaving set mode never counts a stale edge.
  always_ff @(posedge clk_100Mhz) begin
    if (reset) begin
      s1         <= 1'b0;
      s2         <= 1'b0;
      s3         <= 1'b0;
      so         <= 4'd0;
      st         <= 4'd0;
      mo         <= 4'd0;
      mt         <= 4'd0;
      ho         <= HR_RST_O;
      ht         <= HR_RST_T;
      pm_q       <= 1'b0;
      sec_tick_q <= 1'b0;
    end else begin
      s1         <= bus.clk_1hz;
      s2         <= s1;
      s3         <= s2;
      so         <= so_n;
      st         <= st_n;
      mo         <= mo_n;
      mt         <= mt_n;
      ho         <= ho_n;
      ht         <= ht_n;
      pm_q       <= pm_n;
      sec_tick_q <= sec_tick_n;
    end
  end

  assign bus.sec_ones = so;
  assign bus.sec_tens = st;
  assign bus.min_ones = mo;
  assign bus.min_tens = mt;
  assign bus.hr_ones  = ho;
  assign bus.hr_tens  = ht;
  assign bus.pm       = pm_q;
  assign bus.sec_tick = sec_tick_q;

endmodule

// File: tb/tb_time_keeper.sv
// Bench for time_keeper. A 24-hour instance and a 12-hour instance get the
// same stimulus. The reference model keeps the time as seconds-of-day and
// derives both displays from it with plain arithmetic.
module tb_time_keeper;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic one_hz = 1'b0;
  logic set_m  = 1'b0;
  logic inc_m  = 1'b0;
  logic inc_h  = 1'b0;

  time_keeper_if if24 ();
  time_keeper_if if12 ();

  assign if24.clk_1hz  = one_hz;
  assign if24.set_mode = set_m;
  assign if24.inc_min  = inc_m;
  assign if24.inc_hour = inc_h;
  assign if12.clk_1hz  = one_hz;
  assign if12.set_mode = set_m;
  assign if12.inc_min  = inc_m;
  assign if12.inc_hour = inc_h;

  time_keeper #(.MODE_24H(1)) dut24 (.clk_100Mhz(clk), .reset(reset), .bus(if24));
  time_keeper #(.MODE_24H(0)) dut12 (.clk_100Mhz(clk), .reset(reset), .bus(if12));

  wire [49:0] got = {if24.hr_tens, if24.hr_ones, if24.min_tens, if24.min_ones,
                     if24.sec_tens, if24.sec_ones, if24.pm,
                     if12.hr_tens, if12.hr_ones, if12.min_tens, if12.min_ones,
                     if12.sec_tens, if12.sec_ones, if12.pm};
  wire [1:0]  ticks = {if24.sec_tick, if12.sec_tick};

  int n_checks = 0;
  int n_fail   = 0;
  int tod      = 0;           // model time, seconds since midnight
  logic [49:0] exp_q[$];

  // ---------------- reference model ----------------
  function automatic logic [24:0] disp(int t, bit m24);
    int h24, h, m, s;
    bit p;
    h24 = t / 3600;
    m   = (t / 60) % 60;
    s   = t % 60;
    h   = m24 ? h24 : ((h24 % 12 == 0) ? 12 : h24 % 12);
    p   = m24 ? 1'b0 : (h24 >= 12);
    return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10), p};
  endfunction

  function automatic logic [49:0] exp_both(int t);
    return {disp(t, 1'b1), disp(t, 1'b0)};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_tick(int hi);
    one_hz = 1'b1;
    repeat (hi) step();
    one_hz = 1'b0;
    repeat (4) step();
    if (!set_m) tod = (tod + 1) % 86400;
  endtask

  task automatic enter_set();
    set_m = 1'b1;
    step();
    tod = tod - tod % 60;
  endtask

  task automatic exit_set();
    set_m = 1'b0;
    step();
  endtask

  task automatic model_min();
    int m;
    m = (tod / 60) % 60;
    tod = tod + (((m + 1) % 60) - m) * 60;
  endtask

  task automatic model_hour();
    int h;
    h = tod / 3600;
    tod = tod + (((h + 1) % 24) - h) * 3600;
  endtask

  task automatic pulse_min();
    inc_m = 1'b1; step(); inc_m = 1'b0;
    model_min();
  endtask

  task automatic pulse_hour();
    inc_h = 1'b1; step(); inc_h = 1'b0;
    model_hour();
  endtask

  task automatic pulse_both();
    inc_m = 1'b1; inc_h = 1'b1; step(); inc_m = 1'b0; inc_h = 1'b0;
    model_min();
    model_hour();
  endtask

  task automatic set_time(int h, int m);
    int nh, nm;
    enter_set();
    nh = (h - tod / 3600 + 24) % 24;
    repeat (nh) pulse_hour();
    nm = (m - (tod / 60) % 60 + 60) % 60;
    repeat (nm) pulse_min();
    exit_set();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    one_hz = 1'b0; set_m = 1'b0; inc_m = 1'b0; inc_h = 1'b0;
    repeat (3) step();
    reset = 1'b0;
    tod = 0;
    step();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    repeat (3) step();
    n_checks++;
    if (got !== exp_both(0)) begin n_fail++; $display("FAIL reset_time got=%h exp=%h", got, exp_both(0)); end
    n_checks++;
    if (ticks !== 2'b00) begin n_fail++; $display("FAIL reset_tick got=%b exp=00", ticks); end
    reset = 1'b0;
    tod = 0;
    step();
  endtask

  task automatic test_latency();
    for (int i = 0; i < 3; i++) begin
      one_hz = 1'b1;
      step();                          // edge k: first high sample
      step();                          // edge k+1
      n_checks++;
      if (got !== exp_both(tod) || ticks !== 2'b00) begin
        n_fail++; $display("FAIL latency_k1 got=%h/%b exp=%h/00", got, ticks, exp_both(tod));
      end
      step();                          // edge k+2: update
      tod++;
      n_checks++;
      if (got !== exp_both(tod) || ticks !== 2'b11) begin
        n_fail++; $display("FAIL latency_k2 got=%h/%b exp=%h/11", got, ticks, exp_both(tod));
      end
      step();
      n_checks++;
      if (ticks !== 2'b00) begin n_fail++; $display("FAIL latency_k3 got=%b exp=00", ticks); end
      one_hz = 1'b0;
      repeat (4) step();
    end
    n_checks++;
    if (got !== exp_both(3)) begin n_fail++; $display("FAIL three_ticks got=%h exp=%h", got, exp_both(3)); end
  endtask

  task automatic test_rollover();
    set_time(23, 59);
    repeat (59) drive_tick(1);
    n_checks++;
    if (got !== exp_both(86399)) begin n_fail++; $display("FAIL at_235959 got=%h exp=%h", got, exp_both(86399)); end
    one_hz = 1'b1;
    step(); step();
    n_checks++;
    if (got !== exp_both(86399)) begin n_fail++; $display("FAIL before_wrap got=%h exp=%h", got, exp_both(86399)); end
    step();
    tod = 0;
    n_checks++;
    if (got !== exp_both(0)) begin n_fail++; $display("FAIL day_wrap got=%h exp=%h", got, exp_both(0)); end
    one_hz = 1'b0;
    repeat (4) step();
    set_time(11, 59);
    repeat (60) drive_tick(1);
    n_checks++;
    if (got !== exp_both(12 * 3600)) begin n_fail++; $display("FAIL noon got=%h exp=%h", got, exp_both(12 * 3600)); end
  endtask

  task automatic test_set_mode();
    set_time(5, 30);
    repeat (47) drive_tick(1);
    n_checks++;
    if (got !== exp_both(5 * 3600 + 30 * 60 + 47)) begin n_fail++; $display("FAIL run_053047 got=%h exp=%h", got, exp_both(5 * 3600 + 30 * 60 + 47)); end
    enter_set();
    n_checks++;
    if (got !== exp_both(5 * 3600 + 30 * 60)) begin n_fail++; $display("FAIL set_sec_zero got=%h exp=%h", got, exp_both(5 * 3600 + 30 * 60)); end
    repeat (30) pulse_min();
    n_checks++;
    if (got !== exp_both(5 * 3600)) begin n_fail++; $display("FAIL min_wrap_no_carry got=%h exp=%h", got, exp_both(5 * 3600)); end
    pulse_both();
    n_checks++;
    if (got !== exp_both(6 * 3600 + 60)) begin n_fail++; $display("FAIL inc_both got=%h exp=%h", got, exp_both(6 * 3600 + 60)); end
    one_hz = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      n_checks++;
      if (ticks !== 2'b00) begin n_fail++; $display("FAIL set_no_tick got=%b exp=00", ticks); end
    end
    one_hz = 1'b0;
    repeat (4) step();
    n_checks++;
    if (got !== exp_both(tod)) begin n_fail++; $display("FAIL set_ignores_tick got=%h exp=%h", got, exp_both(tod)); end
    exit_set();
    inc_m = 1'b1; inc_h = 1'b1; step(); inc_m = 1'b0; inc_h = 1'b0; step();
    n_checks++;
    if (got !== exp_both(6 * 3600 + 60)) begin n_fail++; $display("FAIL run_inc_ignored got=%h exp=%h", got, exp_both(6 * 3600 + 60)); end
    drive_tick(2);
    n_checks++;
    if (got !== exp_both(6 * 3600 + 61)) begin n_fail++; $display("FAIL resume_mm00 got=%h exp=%h", got, exp_both(6 * 3600 + 61)); end
  endtask

  task automatic test_long_high();
    int p24 = 0;
    int p12 = 0;
    one_hz = 1'b1;
    for (int i = 0; i < 500; i++) begin
      step();
      if (ticks[1]) p24++;
      if (ticks[0]) p12++;
    end
    one_hz = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (ticks[1]) p24++;
      if (ticks[0]) p12++;
    end
    tod = (tod + 1) % 86400;
    n_checks++;
    if (p24 !== 1 || p12 !== 1) begin n_fail++; $display("FAIL long_high_pulses got=%0d/%0d exp=1/1", p24, p12); end
    n_checks++;
    if (got !== exp_both(tod)) begin n_fail++; $display("FAIL long_high_time got=%h exp=%h", got, exp_both(tod)); end
    // Tick lands on the edge where set_mode first reads high.
    drive_tick(1);
    one_hz = 1'b1;
    step(); step();
    set_m = 1'b1;
    step();
    tod = tod - tod % 60;
    n_checks++;
    if (got !== exp_both(tod) || ticks !== 2'b00) begin
      n_fail++; $display("FAIL tick_on_set_entry got=%h/%b exp=%h/00", got, ticks, exp_both(tod));
    end
    one_hz = 1'b0;
    repeat (4) step();
    exit_set();
    repeat (5) step();
    n_checks++;
    if (got !== exp_both(tod)) begin n_fail++; $display("FAIL no_catch_up got=%h exp=%h", got, exp_both(tod)); end
  endtask

  task automatic test_reset_mid_carry();
    do_reset();
    set_time(0, 59);
    repeat (59) drive_tick(1);
    n_checks++;
    if (got !== exp_both(3599)) begin n_fail++; $display("FAIL at_005959 got=%h exp=%h", got, exp_both(3599)); end
    one_hz = 1'b1;
    step(); step();
    reset = 1'b1;
    step();
    tod = 0;
    n_checks++;
    if (got !== exp_both(0) || ticks !== 2'b00) begin
      n_fail++; $display("FAIL reset_mid_carry got=%h/%b exp=%h/00", got, ticks, exp_both(0));
    end
    step();
    reset = 1'b0;
    step();
    step();
    n_checks++;
    if (got !== exp_both(0) || ticks !== 2'b00) begin
      n_fail++; $display("FAIL release_r1 got=%h/%b exp=%h/00", got, ticks, exp_both(0));
    end
    step();
    tod = 1;
    n_checks++;
    if (got !== exp_both(1) || ticks !== 2'b11) begin
      n_fail++; $display("FAIL release_tick got=%h/%b exp=%h/11", got, ticks, exp_both(1));
    end
    one_hz = 1'b0;
    repeat (5) step();
    n_checks++;
    if (got !== exp_both(1)) begin n_fail++; $display("FAIL release_once got=%h exp=%h", got, exp_both(1)); end
  endtask

  task automatic test_random();
    set_time(int'($urandom_range(0, 23)), int'($urandom_range(0, 59)));
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 3))
        0: drive_tick(int'($urandom_range(1, 20)));
        1: begin
          enter_set();
          repeat ($urandom_range(0, 4)) begin
            case ($urandom_range(0, 2))
              0: pulse_min();
              1: pulse_hour();
              default: pulse_both();
            endcase
          end
          exit_set();
        end
        2: begin
          inc_m = 1'($urandom_range(0, 1));
          inc_h = 1'($urandom_range(0, 1));
          step();
          inc_m = 1'b0; inc_h = 1'b0;
          step();
        end
        default: repeat ($urandom_range(1, 5)) drive_tick(1);
      endcase
      exp_q.push_back(exp_both(tod));
      n_checks++;
      if (got !== exp_q[0]) begin n_fail++; $display("FAIL random_%0d got=%h exp=%h", i, got, exp_q[0]); end
      void'(exp_q.pop_front());
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_rollover();
    test_set_mode();
    test_long_high();
    test_reset_mid_carry();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/time_keeper.md
TIME_KEEPER -- requirements
Module: time_keeper

Interface
REQ-001 Parameter MODE_24H, default 1: 1 = 24-hour count 00..23; 0 = 12-hour count 12,01..11 with AM/PM flag.
REQ-002 clk_100Mhz  input  1  system clock; single clock domain for all state.
REQ-003 reset  input  1  reset, synchronous to clk_100Mhz, active-high.
REQ-004 clk_1hz  input  1  1 Hz square wave from the divider; treated as an asynchronous data input, not a clock.
REQ-005 set_mode  input  1  level; 1 = time-setting mode.
REQ-006 inc_min  input  1  single-cycle pulse (pre-debounced); increments minutes in set mode.
REQ-007 inc_hour  input  1  single-cycle pulse (pre-debounced); increments hours in set mode.
REQ-008 sec_ones, sec_tens, min_ones, min_tens, hr_ones, hr_tens  output  4 each  BCD time digits, registered.
REQ-009 pm  output  1  registered; 1 = PM in 12-hour mode; constant 0 when MODE_24H=1.
REQ-010 sec_tick  output  1  registered single-cycle pulse, high for one cycle per counted second.

Function
REQ-011 clk_1hz SHALL pass through a two-flop synchronizer (s1, s2), followed by a history flop (s3); tick = s2 & ~s3.
REQ-012 Latency: if clk_1hz is first sampled high at edge k, s1=1 after k, tick is high during cycle k+1..k+2, and digits and sec_tick update at edge k+2.
REQ-013 One tick per clk_1hz rising edge; a high level of any duration SHALL NOT produce a second tick.
REQ-014 Run mode (set_mode=0), on tick: seconds +1; 59->00 carries to minutes; minutes 59->00 carries to hours; all carries resolve in the same edge.
REQ-015 24-hour hours: 23:59:59 -> 00:00:00 on the next tick.
REQ-016 12-hour hours: sequence 12,01,02..11,12; 11->12 toggles pm; 11:59:59 AM -> 12:00:00 PM; 11:59:59 PM -> 12:00:00 AM.
REQ-017 Every BCD digit SHALL stay within legal range at all times (sec_tens/min_tens 0..5, ones 0..9, hours per mode); no intermediate illegal value is visible.
REQ-018 sec_tick SHALL pulse on the same edge the seconds update, in run mode only.
REQ-019 Set mode (set_mode=1): seconds forced to 00 every cycle; ticks ignored; sec_tick held 0.
REQ-020 Set mode, inc_min: minutes +1, 59->00, no carry into hours.
REQ-021 Set mode, inc_hour: hours +1 with the mode wrap of REQ-015/016 (pm toggles on 11->12 in 12-hour mode); no effect on minutes.
REQ-022 inc_min and inc_hour in the same cycle: both apply in that edge.
REQ-023 inc_min/inc_hour while set_mode=0: ignored.
REQ-024 tick coincident with the cycle set_mode rises: set mode wins; the tick is discarded.
REQ-025 Leaving set mode: counting resumes from MM:00 at the next tick; no catch-up of missed seconds.
REQ-026 Synchronizer and history flops SHALL keep running in set mode, so no stale edge is counted on exit.

Reset
REQ-027 With reset=1 at a clk_100Mhz edge: s1, s2, s3 <= 0; sec_tick <= 0; pm <= 0.
REQ-028 Reset time: 00:00:00 when MODE_24H=1; 12:00:00 AM when MODE_24H=0.
REQ-029 reset SHALL override all other inputs in the same cycle, including mid-carry, and set-mode increments.
REQ-030 If clk_1hz is high when reset releases, exactly one tick is counted, 2 edges after release (defined behaviour, not an error).

Verification
REQ-031 24h; reset; 3 clk_1hz rising edges -> 00:00:03, three sec_tick pulses, each 2 edges after first high sample.
REQ-032 24h; preload by set mode to 23:59, run 59 ticks, then one more -> 23:59:59 then 00:00:00 in one edge.
REQ-033 12h; set 11:59 AM, run 60 ticks -> 12:00:00 pm=1; repeat to 11:59:59 PM +1 -> 12:00:00 pm=0.
REQ-034 Set mode 05:30:47 entry -> seconds 00; inc_min x30 -> minutes 00 with hours still 05; inc_min+inc_hour same cycle -> 06:01.
REQ-035 clk_1hz held high 500 cycles -> exactly one tick; tick on set_mode rising cycle -> seconds stay 00.
REQ-036 Reset asserted at 00:59:59 coincident with tick -> 00:00:00, sec_tick 0.
